// File: rtl/riscy_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, ALU op
// classes, mux select encodings and the supported opcodes.
package riscy_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // ALU operation codes; the upper bit only exists when ALUControl is 4 wide
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decode from the FSM's op class and the instruction funct bits.
// Shifts are only decoded when the ALU control bus is 4 bits wide.
module alu_dec
  import riscy_pkg::*;
#(
  parameter int ACW = 3
) (
  input  alu_op_t        ALUOp,
  input  logic [2:0]     funct3,
  input  logic           funct7,
  input  logic           op5,
  output logic [ACW-1:0] ALUControl
);

  always_comb begin
    ALUControl = ACW'(ALU_ADD);
    case (ALUOp)
      ALUOP_SUB: ALUControl = ACW'(ALU_SUB);
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: if (op5 && funct7) ALUControl = ACW'(ALU_SUB);
          3'b010: ALUControl = ACW'(ALU_SLT);
          3'b110: ALUControl = ACW'(ALU_OR);
          3'b111: ALUControl = ACW'(ALU_AND);
          3'b001: if (ACW == 4) ALUControl = ACW'(ALU_SLL);
          3'b101: if (ACW == 4) ALUControl = funct7 ? ACW'(ALU_SRA) : ACW'(ALU_SRL);
          default: ALUControl = ACW'(ALU_ADD);
        endcase
      end
      default: ALUControl = ACW'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RISC-V control unit: Moore FSM driving datapath selects and
// write enables, plus a retired-instruction counter.
//
// state     | meaning
// FETCH     | read instruction at PC, PC += 4
// DECODE    | register read, OldPC + imm for branch/jal target
// MEMADR    | rs1 + imm effective address
// MEMREAD   | load access, waits for memory
// MEMWB     | write loaded data to rd
// MEMWRITE  | store access, held until memory accepts
// EXECR     | R-type ALU op
// EXECI     | I-type ALU op
// ALUWB     | write ALU result to rd
// BRANCH    | compare rs1/rs2, conditionally load target into PC
// JAL       | rd = OldPC + 4, PC = target
module mc_ctrl
  import riscy_pkg::*;
#(
  parameter int ACW      = 3,
  parameter int WAIT_MEM = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [ACW-1:0]   ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             mem_rdy, op_known, retire;
  logic             pc_write, ir_write, reg_write, mem_write, illegal_raw;
  alu_op_t          alu_op;

  assign mem_rdy  = (WAIT_MEM != 0) ? mem_ready : 1'b1;
  assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_I)  || (op == OP_BR) || (op == OP_JAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Retirement is counted on the cycle an instruction's last state hands back to FETCH
  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                  (state_q == S_BRANCH) || (state_q == S_JAL) ||
                  ((state_q == S_MEMWRITE) && mem_rdy);
  assign instret_d = instret_q + CNT_W'(retire);
  assign instret   = instret_q;

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    illegal_raw = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = RES_ALUOUT;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = RES_ALU;
        ir_write  = mem_rdy;
        pc_write  = mem_rdy;
      end
      S_DECODE: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b01;
        illegal_raw = !op_known;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 2'b10;
        alu_op   = ALUOP_SUB;
        pc_write = (funct3 == 3'b000) ? Zero : (funct3 == 3'b001) ? !Zero : 1'b0;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_write  = 1'b1;
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables and the illegal pulse are gated so nothing escapes while reset is held
  assign PCWrite  = pc_write  & rst_n;
  assign IRWrite  = ir_write  & rst_n;
  assign RegWrite = reg_write & rst_n;
  assign MemWrite = mem_write & rst_n;
  assign illegal  = illegal_raw & rst_n;
  assign ImmSrc   = imm_src_of(op);

  alu_dec #(.ACW(ACW)) u_alu_dec (
    .ALUOp      (alu_op),
    .funct3     (funct3),
    .funct7     (funct7),
    .op5        (op[5]),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a default instance (ACW=3, 32-bit counter) and a
// wide-ALU instance with a 3-bit counter share the same stimulus.
module tb_mc_ctrl;
  import riscy_pkg::*;

  logic       clk, rst_n, funct7, Zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;

  logic        pcw, irw, rw, mw, adr, ill;
  logic [1:0]  sa, sb, rs, imm;
  logic [2:0]  alu;
  logic [31:0] ret;

  logic        pcw4, irw4, rw4, mw4, adr4, ill4;
  logic [1:0]  sa4, sb4, rs4, imm4;
  logic [3:0]  alu4;
  logic [2:0]  ret4;

  int n_cmp = 0;
  int n_err = 0;
  int total = 0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(pcw), .IRWrite(irw),
    .RegWrite(rw), .MemWrite(mw), .AdrSrc(adr), .ALUSrcA(sa), .ALUSrcB(sb),
    .ResultSrc(rs), .ImmSrc(imm), .ALUControl(alu), .illegal(ill), .instret(ret)
  );

  mc_ctrl #(.ACW(4), .WAIT_MEM(1), .CNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(pcw4), .IRWrite(irw4),
    .RegWrite(rw4), .MemWrite(mw4), .AdrSrc(adr4), .ALUSrcA(sa4), .ALUSrcB(sb4),
    .ResultSrc(rs4), .ImmSrc(imm4), .ALUControl(alu4), .illegal(ill4), .instret(ret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7 = f7;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; Zero = 1'b0;
    set_instr(OP_R, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (dut.state_q !== S_FETCH) begin n_err++; $display("FAIL rst_state: got %0d expected %0d", dut.state_q, S_FETCH); end
    n_cmp++; if ({pcw, irw, rw, mw} !== 4'b0000) begin n_err++; $display("FAIL rst_we: got %b expected 0000", {pcw, irw, rw, mw}); end
    n_cmp++; if (ill !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b expected 0", ill); end
    n_cmp++; if (ret !== 32'd0) begin n_err++; $display("FAIL rst_instret: got %0d expected 0", ret); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (irw !== 1'b1 || pcw !== 1'b1) begin n_err++; $display("FAIL fetch_we: got ir=%b pc=%b expected 1/1", irw, pcw); end
  endtask

  task automatic test_add();
    set_instr(OP_R, 3'b000, 1'b0);
    n_cmp++; if ({sa, sb, rs, rw} !== {2'b00, 2'b10, 2'b10, 1'b0}) begin n_err++; $display("FAIL add_fetch: got sa=%b sb=%b rs=%b rw=%b expected 00 10 10 0", sa, sb, rs, rw); end
    tick();
    n_cmp++; if (dut.state_q !== S_DECODE || rw !== 1'b0 || sa !== 2'b01 || sb !== 2'b01) begin n_err++; $display("FAIL add_decode: got st=%0d rw=%b sa=%b sb=%b expected %0d 0 01 01", dut.state_q, rw, sa, sb, S_DECODE); end
    tick();
    n_cmp++; if (dut.state_q !== S_EXECR || rw !== 1'b0) begin n_err++; $display("FAIL add_execr: got st=%0d rw=%b expected %0d 0", dut.state_q, rw, S_EXECR); end
    n_cmp++; if (alu !== 3'b000 || sa !== 2'b10 || sb !== 2'b00) begin n_err++; $display("FAIL add_aluctl: got alu=%b sa=%b sb=%b expected 000 10 00", alu, sa, sb); end
    tick();
    n_cmp++; if (dut.state_q !== S_ALUWB || rw !== 1'b1 || rs !== 2'b00 || ret !== 32'd0) begin n_err++; $display("FAIL add_aluwb: got st=%0d rw=%b rs=%b ret=%0d expected %0d 1 00 0", dut.state_q, rw, rs, ret, S_ALUWB); end
    tick(); total++;
    n_cmp++; if (dut.state_q !== S_FETCH || rw !== 1'b0 || ret !== 32'd1) begin n_err++; $display("FAIL add_retire: got st=%0d rw=%b ret=%0d expected %0d 0 1", dut.state_q, rw, ret, S_FETCH); end
  endtask

  task automatic test_lw_wait();
    set_instr(OP_LW, 3'b010, 1'b0);
    tick(); tick();
    n_cmp++; if (dut.state_q !== S_MEMADR || sa !== 2'b10 || sb !== 2'b01 || imm !== IMM_I) begin n_err++; $display("FAIL lw_memadr: got st=%0d sa=%b sb=%b imm=%b expected %0d 10 01 00", dut.state_q, sa, sb, imm, S_MEMADR); end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) mem_ready = 1'b1;
      #1;
      n_cmp++; if (dut.state_q !== S_MEMREAD || rw !== 1'b0 || adr !== 1'b1) begin n_err++; $display("FAIL lw_hold%0d: got st=%0d rw=%b adr=%b expected %0d 0 1", i, dut.state_q, rw, adr, S_MEMREAD); end
    end
    tick();
    n_cmp++; if (dut.state_q !== S_MEMWB || rs !== 2'b01 || rw !== 1'b1) begin n_err++; $display("FAIL lw_memwb: got st=%0d rs=%b rw=%b expected %0d 01 1", dut.state_q, rs, rw, S_MEMWB); end
    tick(); total++;
    n_cmp++; if (ret !== 32'd2) begin n_err++; $display("FAIL lw_instret: got %0d expected 2", ret); end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [3] = '{3'b000, 3'b001, 3'b001};
    logic       zs  [3] = '{1'b1, 1'b1, 1'b0};
    logic       exp [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      set_instr(OP_BR, f3s[i], 1'b0);
      Zero = zs[i];
      tick(); tick();
      n_cmp++; if (dut.state_q !== S_BRANCH || pcw !== exp[i]) begin n_err++; $display("FAIL br%0d_pcwrite: got st=%0d pcw=%b expected %0d %b", i, dut.state_q, pcw, S_BRANCH, exp[i]); end
      n_cmp++; if (alu !== 3'b001 || imm !== IMM_B) begin n_err++; $display("FAIL br%0d_alu: got alu=%b imm=%b expected 001 10", i, alu, imm); end
      tick(); total++;
    end
    Zero = 1'b0;
    n_cmp++; if (ret !== 32'd5) begin n_err++; $display("FAIL br_instret: got %0d expected 5", ret); end
  endtask

  task automatic test_illegal();
    set_instr(7'b1111111, 3'b000, 1'b0);
    n_cmp++; if (ill !== 1'b0) begin n_err++; $display("FAIL ill_fetch: got %b expected 0", ill); end
    tick();
    n_cmp++; if (dut.state_q !== S_DECODE || ill !== 1'b1) begin n_err++; $display("FAIL ill_decode: got st=%0d ill=%b expected %0d 1", dut.state_q, ill, S_DECODE); end
    tick();
    n_cmp++; if (dut.state_q !== S_FETCH || ill !== 1'b0 || ret !== 32'd5) begin n_err++; $display("FAIL ill_after: got st=%0d ill=%b ret=%0d expected %0d 0 5", dut.state_q, ill, ret, S_FETCH); end
  endtask

  task automatic test_shift();
    set_instr(OP_R, 3'b101, 1'b1);
    tick(); tick();
    n_cmp++; if (alu !== 3'b000) begin n_err++; $display("FAIL sra_acw3: got %b expected 000", alu); end
    n_cmp++; if (alu4 !== 4'b1010) begin n_err++; $display("FAIL sra_acw4: got %b expected 1010", alu4); end
    funct7 = 1'b0; #1;
    n_cmp++; if (alu4 !== 4'b1001) begin n_err++; $display("FAIL srl_acw4: got %b expected 1001", alu4); end
    funct3 = 3'b001; #1;
    n_cmp++; if (alu4 !== 4'b1000 || alu !== 3'b000) begin n_err++; $display("FAIL sll: got a4=%b a3=%b expected 1000 000", alu4, alu); end
    funct3 = 3'b111; #1;
    n_cmp++; if (alu !== 3'b010 || alu4 !== 4'b0010) begin n_err++; $display("FAIL and: got a3=%b a4=%b expected 010 0010", alu, alu4); end
    tick(); tick(); total++;
    n_cmp++; if (ret4 !== 3'(total)) begin n_err++; $display("FAIL shift_instret4: got %0d expected %0d", ret4, total % 8); end
  endtask

  task automatic test_jal();
    set_instr(OP_JAL, 3'b000, 1'b0);
    tick(); tick();
    n_cmp++; if (dut.state_q !== S_JAL || {pcw, rw, sa, sb, rs, imm} !== {1'b1, 1'b1, 2'b01, 2'b10, 2'b00, 2'b11}) begin n_err++; $display("FAIL jal_outs: got st=%0d pcw=%b rw=%b sa=%b sb=%b rs=%b imm=%b expected %0d 1 1 01 10 00 11", dut.state_q, pcw, rw, sa, sb, rs, imm, S_JAL); end
    tick(); total++;
    n_cmp++; if (ret4 !== 3'd7) begin n_err++; $display("FAIL jal_instret4_max: got %0d expected 7", ret4); end
  endtask

  task automatic test_sw_wrap();
    set_instr(OP_SW, 3'b010, 1'b0);
    tick(); tick();
    n_cmp++; if (dut.state_q !== S_MEMADR || imm !== IMM_S) begin n_err++; $display("FAIL sw_memadr: got st=%0d imm=%b expected %0d 01", dut.state_q, imm, S_MEMADR); end
    mem_ready = 1'b0;
    tick();
    n_cmp++; if (dut.state_q !== S_MEMWRITE || mw !== 1'b1 || adr !== 1'b1) begin n_err++; $display("FAIL sw_mw0: got st=%0d mw=%b adr=%b expected %0d 1 1", dut.state_q, mw, adr, S_MEMWRITE); end
    tick();
    n_cmp++; if (dut.state_q !== S_MEMWRITE || mw !== 1'b1 || ret4 !== 3'd7) begin n_err++; $display("FAIL sw_mw1: got st=%0d mw=%b ret4=%0d expected %0d 1 7", dut.state_q, mw, ret4, S_MEMWRITE); end
    mem_ready = 1'b1;
    tick(); total++;
    n_cmp++; if (dut.state_q !== S_FETCH || ret4 !== 3'd0 || ret !== 32'd8) begin n_err++; $display("FAIL sw_wrap: got st=%0d ret4=%0d ret=%0d expected %0d 0 8", dut.state_q, ret4, ret, S_FETCH); end
  endtask

  task automatic test_reset_mid();
    set_instr(OP_LW, 3'b010, 1'b0);
    tick(); tick();
    n_cmp++; if (dut.state_q !== S_MEMADR) begin n_err++; $display("FAIL mid_memadr: got %0d expected %0d", dut.state_q, S_MEMADR); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dut.state_q !== S_FETCH || {pcw, irw, rw, mw} !== 4'b0000) begin n_err++; $display("FAIL mid_rst: got st=%0d we=%b expected %0d 0000", dut.state_q, {pcw, irw, rw, mw}, S_FETCH); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (dut.state_q !== S_FETCH || ret !== 32'd0 || irw !== 1'b1) begin n_err++; $display("FAIL mid_release: got st=%0d ret=%0d irw=%b expected %0d 0 1", dut.state_q, ret, irw, S_FETCH); end
    tick();
    n_cmp++; if (dut.state_q !== S_DECODE) begin n_err++; $display("FAIL mid_next: got %0d expected %0d", dut.state_q, S_DECODE); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_shift();
    test_jal();
    test_sw_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter ACW, default 3: ALUControl width; legal values 3 or 4.
REQ-002 Parameter WAIT_MEM, default 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
REQ-003 Parameter CNT_W, default 32: width of the instret counter.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 op  in  7  opcode field of the instruction register.
REQ-007 funct3  in  3  instruction funct3 field.
REQ-008 funct7  in  1  instruction bit 30.
REQ-009 Zero  in  1  ALU result equals zero.
REQ-010 mem_ready  in  1  memory access completes in the current cycle.
REQ-011 PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables.
REQ-012 AdrSrc  out  1  memory address select: 0 = PC, 1 = result.
REQ-013 ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-014 ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
REQ-015 ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result.
REQ-016 ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-017 ALUControl  out  ACW  ALU operation.
REQ-018 illegal  out  1  one-cycle pulse on an unsupported opcode.
REQ-019 instret  out  CNT_W  count of retired instructions.

Function
REQ-020 Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
REQ-021 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-022 DECODE: ALUSrcA=01, ALUSrcB=01, ALU add. Next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL; any other op -> FETCH with illegal=1.
REQ-023 MEMADR: ALUSrcA=10, ALUSrcB=01, ALU add. Next state is MEMREAD for lw, MEMWRITE for sw.
REQ-024 MEMREAD: AdrSrc=1, ResultSrc=00; wait for mem_ready, then go to MEMWB. MEMWB: ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-025 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready; then go to FETCH.
REQ-026 EXECR: ALUSrcA=10, ALUSrcB=00. EXECI: ALUSrcA=10, ALUSrcB=01. Both go to ALUWB.
REQ-027 ALUWB: ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-028 BRANCH: ALUSrcA=10, ALUSrcB=00, ALU sub, ResultSrc=00. PCWrite=Zero for funct3 000 and PCWrite=~Zero for funct3 001; then go to FETCH.
REQ-029 JAL: ALUSrcA=01, ALUSrcB=10, ALU add, ResultSrc=00, PCWrite=1, RegWrite=1, then go to FETCH.
REQ-030 ImmSrc is driven from op in every state: sw=01, branch=10, jal=11, otherwise 00.
REQ-031 ALU decode (ACW=3): add 000, sub 001 (R-type with funct7=1, and branches), and 010 for funct3 111, or 011 for funct3 110, slt 101 for funct3 010.
REQ-032 With ACW=4: additionally sll 1000 (funct3 001), srl 1001 (funct3 101, funct7=0), sra 1010 (funct3 101, funct7=1). Unsupported funct3 values decode to add. With ACW=3 the shift funct3 values decode to add.
REQ-033 instret increments by 1 on the cycle that leaves MEMWB, MEMWRITE, ALUWB, BRANCH or JAL; it wraps modulo 2^CNT_W.
REQ-034 Outputs depend only on state, op, funct3, funct7, Zero and mem_ready; there is no output register latency.

Reset
REQ-035 While rst_n=0: state=FETCH, instret=0, illegal=0, and PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
REQ-036 Reset asserted mid-instruction abandons that instruction; the first cycle after release is FETCH.

Structure
REQ-037 The state enum and the ALUControl/ImmSrc/ResultSrc encodings SHALL live in shared package riscy_pkg.
REQ-038 ALU decoding SHALL be a sub-module alu_dec (inputs: ALUOp, funct3, funct7, op bit 5; output: ALUControl).

Verification
REQ-039 Reset, then add (op 0110011, funct7=0), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; ALUControl=000; RegWrite=1 only in ALUWB; instret=1.
REQ-040 lw with mem_ready held 0 for 3 cycles in MEMREAD -> FSM holds in MEMREAD for 4 cycles with RegWrite=0; MEMWB then has ResultSrc=01 and RegWrite=1.
REQ-041 beq with Zero=1 -> PCWrite=1 in BRANCH; bne (funct3 001) with Zero=1 -> PCWrite=0; ALUControl=001 in both.
REQ-042 op 1111111 -> illegal=1 for exactly one cycle in DECODE, then FETCH; instret unchanged.
REQ-043 With ACW=4, sra (funct3 101, funct7=1) -> ALUControl=1010; with ACW=3 the same instruction gives 000.
REQ-044 Set instret to 2^CNT_W-1, then retire one instruction -> instret=0; rst_n pulsed low in MEMADR -> FETCH with all write enables 0.
